// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: computes |A - B| one digit per clock, LS digit first,
// with a sign flag; a negative raw result is corrected by a second ten's-complement pass.
module bcd_serial_subtractor #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [4*NDIGITS-1:0] a_in,
  input  logic [4*NDIGITS-1:0] b_in,
  output logic [4*NDIGITS-1:0] diff_out,
  output logic                 neg_out,
  output logic                 invalid_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [CW-1:0]   cnt;
  logic            borrow;

  logic [3:0]      min_d;
  logic [3:0]      sub_d;
  logic [4:0]      t;
  logic [3:0]      res_d;
  logic            res_borrow;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One shared digit subtractor serves both passes: RUN computes a[i]-b[i], NEG
  // computes 0-d[i], which turns the wrapped result into its ten's complement.
  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    min_d = a_reg[4*cnt +: 4];
    sub_d = b_reg[4*cnt +: 4];
    if (state == NEG) begin
      min_d = 4'd0;
      sub_d = diff_out[4*cnt +: 4];
    end
    t          = {1'b0, min_d} - {1'b0, sub_d} - {4'b0, borrow};
    res_borrow = t[4];
    res_d      = res_borrow ? 4'(t + 5'd10) : t[3:0];
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    // NOTE: the operand latches are reset along with the control state; they are
    // only a few flops, and this keeps the block free of X after reset.
    if (rst_in) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt         <= '0;
      borrow      <= 1'b0;
      diff_out    <= '0;
      neg_out     <= 1'b0;
      invalid_out <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
            cnt      <= '0;
            borrow   <= 1'b0;
            diff_out <= '0;
            neg_out  <= 1'b0;
            if (has_bad_digit(a_in) || has_bad_digit(b_in)) begin
              invalid_out <= 1'b1;
              done_out    <= 1'b1;
              state       <= DONE;
            end else begin
              invalid_out <= 1'b0;
              busy_out    <= 1'b1;
              state       <= RUN;
            end
          end
        end

        RUN: begin
          diff_out[4*cnt +: 4] <= res_d;
          if (cnt == LAST) begin
            cnt    <= '0;
            borrow <= 1'b0;
            if (res_borrow) begin
              // A < B: the stored digits are A - B + 10^N; fix them up in place.
              neg_out <= 1'b1;
              state   <= NEG;
            end else begin
              busy_out <= 1'b0;
              done_out <= 1'b1;
              state    <= DONE;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            borrow <= res_borrow;
          end
        end

        NEG: begin
          diff_out[4*cnt +: 4] <= res_d;
          if (cnt == LAST) begin
            cnt      <= '0;
            borrow   <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            state    <= DONE;
          end else begin
            cnt    <= cnt + 1'b1;
            borrow <= res_borrow;
          end
        end

        DONE: begin
          done_out <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          busy_out <= 1'b0;
          done_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
